// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: ROUND_ROBIN_EN (see mem_arb_prio).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wide enough for RD_LAT_MAX-2, the largest wait reload value.
  localparam int WAIT_CNT_W = 2;

  // Keeps an out-of-range latency parameter inside the legal window.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection for the two request ports.
// ROUND_ROBIN_EN: favoured-port pointer; otherwise port 0 fixed priority.
module mem_arb_prio
  import mem_arb_pkg::*;
(
`ifdef ROUND_ROBIN_EN
  input  logic Clk,
  input  logic Reset,
  input  logic upd_i,
  input  logic served_i,
`endif
  input  logic req0,
  input  logic req1,
  output logic any_o,
  output logic winner_o
);

  logic fav;

`ifdef ROUND_ROBIN_EN
  logic ptr_q;

  // Pointer favours the port that was not served in the last DONE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= PORT0;
    end else if (upd_i) begin
      ptr_q <= ~served_i;
    end
  end

  assign fav = ptr_q;
`else
  assign fav = PORT0;
`endif

  assign any_o = req0 | req1;

  // Winner decode; contention resolved by the favoured port.
  always_comb begin
    winner_o = PORT0;
    unique case (1'b1)
      (req0 && req1):  winner_o = fav;
      (req1 && !req0): winner_o = PORT1;
      default:         winner_o = PORT0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: IDLE/ISSUE/WAIT/DONE transaction FSM.
// ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT = clamp_lat(RD_LAT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((LAT > 1) ? LAT - 2 : 0);

  arb_state_e state_q;

  logic                  port_q;
  logic                  we_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic                  busy_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [DATA_W-1:0]     rdata_q;

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_prio u_prio (
`ifdef ROUND_ROBIN_EN
    .Clk      (Clk),
    .Reset    (Reset),
    .upd_i    (state_q == S_DONE),
    .served_i (port_q),
`endif
    .req0     (req0),
    .req1     (req1),
    .any_o    (any_req),
    .winner_o (win)
  );

  // Route the winning port's request fields to the latch.
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (win == PORT1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      port_q      <= PORT0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q     <= S_ISSUE;
            port_q      <= win;
            we_q        <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we;
            gnt0_q      <= (win == PORT0);
            gnt1_q      <= (win == PORT1);
            busy_q      <= 1'b1;
          end
        end
        S_ISSUE: begin
          mem_we_q <= 1'b0;
          if (we_q || LAT == 1) begin
            state_q <= S_DONE;
            ack0_q  <= (port_q == PORT0);
            ack1_q  <= (port_q == PORT1);
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            ack0_q  <= (port_q == PORT0);
            ack1_q  <= (port_q == PORT1);
            rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
          busy_q      <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scenario tasks plus randomized traffic.
// Define ROUND_ROBIN_EN for both bench and RTL to check that build.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int PI = (RL > 1) ? RL - 2 : 0;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, ack0, ack1, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Memory device with RL-cycle read latency from the address edge.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [4];

  always @(posedge Clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem[mem_addr];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end

  assign mem_rdata = (RL == 1) ? mem[mem_addr] : pipe[PI];

  // Reference model state.
  int            vec = 0;
  int            errs = 0;
  bit            rr = 1'b0;
  int            last_srv = -1;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rdata = '0;

  task automatic txn(
    input bit r0, input bit r1, input bit w0, input bit w1,
    input logic [AW-1:0] a0, input logic [AW-1:0] a1,
    input logic [DW-1:0] d0, input logic [DW-1:0] d1,
    input bit hold, input bit drop, input bit scram,
    output int obs);
    int win, len;
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0] eg, ea;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    if (r0 && r1) win = (rr && last_srv == 0) ? 1 : 0;
    else win = r1 ? 1 : 0;
    we = win ? w1 : w0;
    a = win ? a1 : a0;
    d = win ? d1 : d0;
    len = we ? 2 : RL + 1;
    obs = -1;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge Clk);
      eg = (k <= len) ? (win ? 2'b10 : 2'b01) : 2'b00;
      ea = (k == len) ? eg : 2'b00;
      if (k == len && !we) exp_rdata = ref_mem[a];
      if (k == 1) obs = gnt1 ? 1 : (gnt0 ? 0 : -1);
      vec++;
      if ({gnt1, gnt0} !== eg) begin
        errs++;
        $display("FAIL gnt k=%0d got %b want %b", k, {gnt1, gnt0}, eg);
      end
      vec++;
      if ({ack1, ack0} !== ea) begin
        errs++;
        $display("FAIL ack k=%0d got %b want %b", k, {ack1, ack0}, ea);
      end
      vec++;
      if (busy !== (k <= len)) begin
        errs++;
        $display("FAIL busy k=%0d got %b want %b", k, busy, k <= len);
      end
      vec++;
      if (mem_we !== (we && k == 1)) begin
        errs++;
        $display("FAIL mem_we k=%0d got %b want %b", k, mem_we, we && k == 1);
      end
      vec++;
      if (rdata !== exp_rdata) begin
        errs++;
        $display("FAIL rdata k=%0d got %h want %h", k, rdata, exp_rdata);
      end
      if (k < len) begin
        vec++;
        if (mem_addr !== a) begin
          errs++;
          $display("FAIL mem_addr k=%0d got %h want %h", k, mem_addr, a);
        end
      end
      if (k == 1) begin
        vec++;
        if (mem_wdata !== d) begin
          errs++;
          $display("FAIL mem_wdata got %h want %h", mem_wdata, d);
        end
      end
      if (k == len + 1) begin
        vec++;
        if ({mem_addr, mem_wdata} !== '0) begin
          errs++;
          $display("FAIL idle_bus got %h/%h want 0", mem_addr, mem_wdata);
        end
      end
      if (k == 1 && drop) begin
        if (win) req1 = 1'b0;
        else req0 = 1'b0;
      end
      if (k == 1 && scram) begin
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = AW'($urandom); addr1 = AW'($urandom);
        wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      end
      if (k == len && !hold) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    last_srv = win;
    if (we) ref_mem[a] = d;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    last_srv = -1;
    exp_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    @(negedge Clk);
    vec++;
    if ({gnt0, gnt1, ack0, ack1, busy, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      errs++;
      $display("FAIL reset_out got %b want 0",
        {gnt0, gnt1, ack0, ack1, busy, mem_we});
    end
    Reset = 1'b1;
  endtask

  task automatic test_read();
    int o;
    txn(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0, o);
    vec++;
    if (rdata !== 8'hA5) begin
      errs++;
      $display("FAIL read_a5 got %h want a5", rdata);
    end
  endtask

  task automatic test_write();
    int o;
    txn(0, 1, 0, 1, 8'h00, 8'h80, 8'h00, 8'h3C, 0, 0, 0, o);
    vec++;
    if (mem[8'h80] !== 8'h3C) begin
      errs++;
      $display("FAIL write_mem got %h want 3c", mem[8'h80]);
    end
    txn(1, 0, 0, 0, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 0, o);
  endtask

  task automatic test_back_to_back();
    int o;
    int want [3];
    apply_reset();
    want[0] = 0;
    want[1] = rr ? 1 : 0;
    want[2] = 0;
    for (int t = 0; t < 3; t++) begin
      txn(1, 1, 1, 1, 8'(t), 8'(t + 8), 8'(t + 1), 8'(t + 9),
          (t < 2), 0, 0, o);
      vec++;
      if (o !== want[t]) begin
        errs++;
        $display("FAIL order t=%0d got %0d want %0d", t, o, want[t]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int o;
    @(negedge Clk);
    req0 = 1'b1;
    we0 = 1'b0;
    addr0 = 8'h05;
    for (int k = 0; k < RL; k++) @(negedge Clk);
    #2;
    Reset = 1'b0;
    req0 = 1'b0;
    exp_rdata = '0;
    last_srv = -1;
    #1;
    vec++;
    if ({gnt0, gnt1, ack0, ack1, busy, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      errs++;
      $display("FAIL reset_mid got %b want 0",
        {gnt0, gnt1, ack0, ack1, busy, mem_we});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      vec++;
      if ({ack0, ack1, busy} !== 3'b000) begin
        errs++;
        $display("FAIL reset_noack got %b want 000", {ack0, ack1, busy});
      end
    end
    Reset = 1'b1;
    txn(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0, o);
  endtask

  task automatic test_drop();
    int o;
    apply_reset();
    txn(1, 1, 0, 1, 8'h03, 8'h04, 8'h00, 8'h77, 1, 1, 0, o);
    txn(0, 1, 0, 1, 8'h03, 8'h04, 8'h00, 8'h77, 0, 0, 0, o);
    vec++;
    if (o !== 1) begin
      errs++;
      $display("FAIL drop_next got %0d want 1", o);
    end
  endtask

  task automatic test_latch();
    int o;
    txn(1, 0, 1, 0, 8'h06, 8'h00, 8'h5A, 8'h00, 0, 0, 1, o);
    txn(0, 1, 0, 0, 8'h00, 8'h06, 8'h00, 8'h00, 0, 0, 1, o);
  endtask

  task automatic test_random();
    int o;
    bit r0, r1;
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      txn(r0, r1, 1'($urandom), 1'($urandom),
          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
          DW'($urandom), DW'($urandom),
          0, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0), o);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
`ifdef ROUND_ROBIN_EN
    rr = 1'b1;
`endif
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    mem[8'h10] <= 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_latch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
